// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA priority arbiter: requests the bus with HRQ, grants one channel
// with DACK once HLDA arrives, and optionally rotates priority after each service.
module dma_priority_arbiter #(
    parameter bit DREQ_SYNC = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] DREQ,
    input  logic [3:0] maskReg,
    input  logic [3:0] requestReg,
    input  logic       priorityType,
    input  logic       HLDA,
    input  logic       transferDone,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic [1:0] grantChannel,
    output logic [3:0] reqServiced,
    output logic [7:0] priorityOrder
);

    localparam logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } arbStateT;

    arbStateT   state;
    arbStateT   nextState;
    logic [3:0] dreqS;
    logic [3:0] eff;
    logic       anyReq;
    logic [1:0] winner;
    logic       found;
    logic       grantLoad;
    logic       complete;

    // Completed channel drops to the lowest slot; its successor becomes highest.
    function automatic logic [7:0] rotateAfter(input logic [1:0] k);
        return {k, k + 2'd3, k + 2'd2, k + 2'd1};
    endfunction

    generate
        if (DREQ_SYNC) begin : gSync
            logic [3:0] syncMeta;
            logic [3:0] syncOut;

            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge value; blocking here would collapse the two stages.
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    syncMeta <= '0;
                    syncOut  <= '0;
                end else begin
                    syncMeta <= DREQ;
                    syncOut  <= syncMeta;
                end
            end

            assign dreqS = syncOut;
        end else begin : gNoSync
            assign dreqS = DREQ;
        end
    endgenerate

    assign eff    = (dreqS & ~maskReg) | requestReg;
    assign anyReq = |eff;

    // First slot (highest priority first) whose channel has an effective request.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        winner = priorityOrder[1:0];
        found  = 1'b0;
        for (int slot = 0; slot < 4; slot++) begin
            if (!found && eff[priorityOrder[2*slot +: 2]]) begin
                winner = priorityOrder[2*slot +: 2];
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        grantLoad = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (anyReq) nextState = REQ;
            end
            REQ: begin
                if (HLDA && anyReq) begin
                    nextState = GRANT;
                    grantLoad = 1'b1;
                end else if (!HLDA && !anyReq) begin
                    nextState = IDLE;
                end
            end
            GRANT: begin
                // Completion wins over a simultaneous loss of HLDA.
                if (transferDone) begin
                    nextState = RELEASE;
                    complete  = 1'b1;
                end else if (!HLDA) begin
                    nextState = IDLE;
                end
            end
            RELEASE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            HRQ           <= 1'b0;
            DACK          <= '0;
            grantChannel  <= '0;
            reqServiced   <= '0;
            priorityOrder <= DEFAULT_ORDER;
        end else begin
            state       <= nextState;
            HRQ         <= (nextState == REQ) || (nextState == GRANT);
            reqServiced <= '0;

            if (grantLoad) begin
                grantChannel <= winner;
                DACK         <= 4'b0001 << winner;
            end else if (nextState != GRANT) begin
                DACK <= '0;
            end

            if (complete) reqServiced <= 4'b0001 << grantChannel;

            if (!priorityType) begin
                priorityOrder <= DEFAULT_ORDER;
            end else if (complete) begin
                priorityOrder <= rotateAfter(grantChannel);
            end
        end
    end

    dackOneHot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(DACK));
    dackNeedsHrq: assert property (@(posedge CLK) disable iff (RESET) (DACK != 4'b0000) |-> HRQ);
    servicedInRelease: assert property (@(posedge CLK) disable iff (RESET)
        (reqServiced != 4'b0000) |-> (state == RELEASE));

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter: a table of fixed-priority grants plus
// hand-written sequences for withdrawal, abort, rotation, sync latency and reset.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] DREQ;
    logic [3:0] maskReg;
    logic [3:0] requestReg;
    logic       priorityType;
    logic       HLDA;
    logic       transferDone;
    logic       HRQ;
    logic [3:0] DACK;
    logic [1:0] grantChannel;
    logic [3:0] reqServiced;
    logic [7:0] priorityOrder;

    logic       hrqS;
    logic [3:0] dackS;
    logic [1:0] grantChannelS;
    logic [3:0] reqServicedS;
    logic [7:0] priorityOrderS;

    int totalChecks  = 0;
    int passedChecks = 0;

    typedef struct {
        string      name;
        logic [3:0] dreq;
        logic [3:0] mask;
        logic [3:0] swReq;
        logic [3:0] expDack;
    } vecT;

    vecT vecs[8];

    always #5 CLK = ~CLK;

    dma_priority_arbiter #(.DREQ_SYNC(1'b0)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .maskReg      (maskReg),
        .requestReg   (requestReg),
        .priorityType (priorityType),
        .HLDA         (HLDA),
        .transferDone (transferDone),
        .HRQ          (HRQ),
        .DACK         (DACK),
        .grantChannel (grantChannel),
        .reqServiced  (reqServiced),
        .priorityOrder(priorityOrder)
    );

    dma_priority_arbiter #(.DREQ_SYNC(1'b1)) dutS (
        .CLK          (CLK),
        .RESET        (RESET),
        .DREQ         (DREQ),
        .maskReg      (maskReg),
        .requestReg   (requestReg),
        .priorityType (priorityType),
        .HLDA         (HLDA),
        .transferDone (transferDone),
        .HRQ          (hrqS),
        .DACK         (dackS),
        .grantChannel (grantChannelS),
        .reqServiced  (reqServicedS),
        .priorityOrder(priorityOrderS)
    );

    task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            $display("FAIL %s: got %b, expected %b", name, actual, expected);
        end else begin
            passedChecks++;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [1:0] idxOf(input logic [3:0] oneHot);
        logic [1:0] idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oneHot[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // One full service: wait for HRQ, acknowledge, complete, and check each phase.
    task automatic doService(input string name, input logic [3:0] expDack);
        int waitCnt = 0;
        while (HRQ !== 1'b1 && waitCnt < 10) begin
            step();
            waitCnt++;
        end
        check({name, " hrq rises"}, {7'd0, HRQ}, 8'd1);
        HLDA = 1'b1;
        step();
        check({name, " dack"}, {4'd0, DACK}, {4'd0, expDack});
        check({name, " grantChannel"}, {6'd0, grantChannel}, {6'd0, idxOf(expDack)});
        transferDone = 1'b1;
        step();
        check({name, " reqServiced"}, {4'd0, reqServiced}, {4'd0, expDack});
        check({name, " release hrq"}, {7'd0, HRQ}, 8'd0);
        check({name, " release dack"}, {4'd0, DACK}, 8'd0);
        transferDone = 1'b0;
        HLDA         = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"fixed 1010",      4'b1010, 4'b0000, 4'b0000, 4'b0010};
        vecs[1] = '{"fixed 1000",      4'b1000, 4'b0000, 4'b0000, 4'b1000};
        vecs[2] = '{"sw only",         4'b0000, 4'b0000, 4'b0100, 4'b0100};
        vecs[3] = '{"mask vs sw",      4'b0001, 4'b0001, 4'b0100, 4'b0100};
        vecs[4] = '{"mask low three",  4'b1111, 4'b0111, 4'b0000, 4'b1000};
        vecs[5] = '{"mask ch1",        4'b0110, 4'b0010, 4'b0000, 4'b0100};
        vecs[6] = '{"all masked sw",   4'b0000, 4'b1111, 4'b1001, 4'b0001};
        vecs[7] = '{"sw beats masked", 4'b1100, 4'b0100, 4'b0010, 4'b0010};

        RESET        = 1'b1;
        DREQ         = '0;
        maskReg      = '0;
        requestReg   = '0;
        priorityType = 1'b0;
        HLDA         = 1'b0;
        transferDone = 1'b0;

        #2;
        check("reset hrq", {7'd0, HRQ}, 8'd0);
        check("reset dack", {4'd0, DACK}, 8'd0);
        check("reset grantChannel", {6'd0, grantChannel}, 8'd0);
        check("reset reqServiced", {4'd0, reqServiced}, 8'd0);
        check("reset priorityOrder", priorityOrder, 8'b11_10_01_00);
        step();
        step();
        RESET = 1'b0;
        step();

        // Synchronized instance sees DREQ two cycles later than the direct one.
        DREQ = 4'b0001;
        step();
        check("sync0 hrq after 1", {7'd0, HRQ}, 8'd1);
        check("sync1 hrq after 1", {7'd0, hrqS}, 8'd0);
        step();
        check("sync1 hrq after 2", {7'd0, hrqS}, 8'd0);
        step();
        check("sync1 hrq after 3", {7'd0, hrqS}, 8'd1);
        DREQ = 4'b0000;
        step();
        check("sync0 hrq drop", {7'd0, HRQ}, 8'd0);
        for (int i = 0; i < 4; i++) step();

        for (int v = 0; v < 8; v++) begin
            DREQ       = vecs[v].dreq;
            maskReg    = vecs[v].mask;
            requestReg = vecs[v].swReq;
            doService(vecs[v].name, vecs[v].expDack);
            DREQ       = '0;
            maskReg    = '0;
            requestReg = '0;
            step();
            check({vecs[v].name, " pulse ends"}, {4'd0, reqServiced}, 8'd0);
            step();
        end

        // Masked hardware request alone never raises HRQ.
        maskReg = 4'b0001;
        DREQ    = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            check("masked no hrq", {7'd0, HRQ}, 8'd0);
        end
        maskReg = '0;
        DREQ    = '0;
        step();

        // Withdrawal before HLDA.
        DREQ = 4'b0001;
        step();
        check("withdraw hrq up", {7'd0, HRQ}, 8'd1);
        DREQ = 4'b0000;
        step();
        check("withdraw hrq down", {7'd0, HRQ}, 8'd0);
        check("withdraw dack", {4'd0, DACK}, 8'd0);
        step();
        check("withdraw stays idle", {7'd0, HRQ}, 8'd0);

        // Abort in rotating mode: no pulse, no rotation.
        priorityType = 1'b1;
        DREQ         = 4'b0010;
        step();
        check("abort hrq up", {7'd0, HRQ}, 8'd1);
        HLDA = 1'b1;
        step();
        check("abort dack", {4'd0, DACK}, 8'b0000_0010);
        HLDA = 1'b0;
        DREQ = 4'b0000;
        step();
        check("abort dack drop", {4'd0, DACK}, 8'd0);
        check("abort hrq drop", {7'd0, HRQ}, 8'd0);
        check("abort no serviced", {4'd0, reqServiced}, 8'd0);
        check("abort order kept", priorityOrder, 8'b11_10_01_00);
        step();

        // transferDone together with HLDA low counts as completion.
        DREQ = 4'b0100;
        step();
        HLDA = 1'b1;
        step();
        check("simul dack", {4'd0, DACK}, 8'b0000_0100);
        transferDone = 1'b1;
        HLDA         = 1'b0;
        DREQ         = 4'b0000;
        step();
        check("simul serviced", {4'd0, reqServiced}, 8'b0000_0100);
        check("simul rotated", priorityOrder, 8'b10_01_00_11);
        transferDone = 1'b0;
        priorityType = 1'b0;
        step();
        check("fixed restored", priorityOrder, 8'b11_10_01_00);
        step();

        // Rotating, all channels requesting.
        priorityType = 1'b1;
        DREQ         = 4'b1111;
        doService("rot1", 4'b0001);
        check("rot1 order", priorityOrder, 8'b00_11_10_01);
        doService("rot2", 4'b0010);
        check("rot2 order", priorityOrder, 8'b01_00_11_10);
        doService("rot3", 4'b0100);
        check("rot3 order", priorityOrder, 8'b10_01_00_11);

        // Fourth grant goes to channel 3; reset asserted mid-GRANT.
        begin
            int waitCnt = 0;
            while (HRQ !== 1'b1 && waitCnt < 10) begin
                step();
                waitCnt++;
            end
            check("rot4 hrq rises", {7'd0, HRQ}, 8'd1);
        end
        HLDA = 1'b1;
        step();
        check("rot4 dack", {4'd0, DACK}, 8'b0000_1000);
        RESET = 1'b1;
        #2;
        check("async reset dack", {4'd0, DACK}, 8'd0);
        check("async reset hrq", {7'd0, HRQ}, 8'd0);
        check("async reset order", priorityOrder, 8'b11_10_01_00);
        check("async reset serviced", {4'd0, reqServiced}, 8'd0);
        HLDA         = 1'b0;
        DREQ         = 4'b0000;
        priorityType = 1'b0;
        step();
        RESET = 1'b0;
        step();
        check("post reset hrq", {7'd0, HRQ}, 8'd0);
        check("post reset dack", {4'd0, DACK}, 8'd0);

        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
